irq_request_latch: RTL
======================

# irq_request_latch

Upstream stage for the 8-to-3 priority encoder. Synchronizes eight asynchronous request lines, detects their rising edges, and holds each as a sticky pending bit. It masks the pending bits and presents them as the encoder's 8-bit input vector and enable. The pending bit of the serviced line is cleared when the consumer acknowledges it with the encoded 3-bit index.

## Interface
- SYNC_STAGES, 2, synchronizer depth per request line; legal range 2..4.
- MASK_RESET, 8'h00, mask register value after reset; 1 = line enabled.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronous to clk.
- irq_in  input  8  asynchronous request lines, active-high; level held ≥ SYNC_STAGES+1 clk periods.
- mask_wr  input  1  write strobe for the mask register.
- mask_data  input  8  new mask value, captured when mask_wr=1.
- ack_valid  input  1  acknowledge strobe; one-cycle pulse per serviced request.
- ack_id  input  3  index of the line being acknowledged (encoder output).
- req_vec  output  8  pending & mask; drives the encoder data input.
- req_en  output  1  OR-reduction of req_vec; drives the encoder enable.
- pending  output  8  raw pending register, unmasked.
- overrun  output  8  sticky per line: a new edge arrived while the pending bit was already set.

## Operation
- Per line i: SYNC_STAGES-deep flop chain, then one history flop `prev`. rise[i] = sync_out[i] & ~prev[i].
- Pending update each cycle, per line: set if rise[i]. Else clear if ack_valid && ack_id==i. Else hold.
- Simultaneous rise and ack on the same line: set wins and overrun is not set. The new edge is kept; the old edge counts as serviced.
- Overrun update per line: set if rise[i] && pending[i] && !(ack_valid && ack_id==i). Cleared by ack of that line, unless it is set again in the same cycle.
- Ack of a line whose pending bit is 0: no effect, no error flag.
- Masking affects only req_vec and req_en. Masked lines still latch pending and overrun. Unmasking a pending line presents it on the next cycle.
- mask_wr: the mask register loads mask_data at the clock edge. A mask write and an ack in the same cycle are independent.
- req_vec and req_en are combinational from registers only (pending, mask). There is no combinational path from any input port to any output.
- Reset values: sync chain 0, prev 0, pending 8'h00, overrun 8'h00, mask MASK_RESET, req_vec 8'h00, req_en 0.
- A line held high across reset release produces exactly one rise after release; this is intended.
- Reset mid-operation: all pending, overrun and in-flight sync state is discarded immediately. No acks are required afterwards.

## Timing
- irq_in rising, first sampled at clock edge k: pending[i]=1 after edge k+SYNC_STAGES. req_vec and req_en reflect it in the same cycle if the line is unmasked.
- Ack sampled at edge m: pending[i]=0 after edge m. The encoder sees the updated vector in cycle m+1 and can present the next-highest line.
- A line must return low for ≥ SYNC_STAGES+1 cycles before another rise can be detected.
- Mask write at edge m: req_vec uses the new mask from cycle m+1.

## Test plan
- Reset, SYNC_STAGES=2, MASK_RESET=8'h00: write mask 8'hFF, pulse irq_in[5] high for 4 cycles. Required: pending=8'h20 exactly 2 edges after first sample, req_vec=8'h20, req_en=1. Ack id 5 → pending=8'h00, req_en=0 next cycle.
- Mask 8'h0F, raise irq_in[7] and irq_in[2] together. Required: pending=8'h84, req_vec=8'h04. Write mask 8'hFF → req_vec=8'h84. Ack 7 then ack 2 → req_vec=8'h04, then 8'h00.
- Rising edge on line 3 while pending[3]=1 with no ack → overrun=8'h08. Ack 3 → pending[3]=0, overrun=8'h00.
- Rise on line 1 detected in the same cycle as ack_id=1 → pending[1] stays 1 and overrun[1] stays 0. Ack of non-pending line 6 → no register changes.
- Latch pending=8'hFF, assert rst_n=0 mid-cycle → all outputs 0 immediately. Release with irq_in=8'h01 held high → pending=8'h01 after 2 edges; mask returns to MASK_RESET.
- irq_in[4] toggles high/low every cycle (violates hold rule): no X on outputs, pending[4] only ever 0/1. Then hold it high 4 cycles → exactly one set.

Source files
------------

// File: rtl/irq_request_latch.sv
// irq_request_latch
// Front end for the 8-to-3 priority encoder.
// Each of the eight asynchronous request lines passes through a synchronizer.
// A rising edge on a line sets a sticky pending bit.
// The pending bits are masked and handed to the encoder as req_vec / req_en.
// The consumer clears a line by acknowledging it with the encoded index.
// SYNC_STAGES is the synchronizer depth; legal values are 2 to 4.
module irq_request_latch #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] MASK_RESET  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
    input  logic       ack_valid,
    input  logic [2:0] ack_id,
    output logic [7:0] req_vec,
    output logic       req_en,
    output logic [7:0] pending,
    output logic [7:0] overrun
);

    // Synchronizer chain: index 0 samples the pins, and the last index is the
    // synchronized level.
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];

    logic [7:0] prev_q,    prev_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] overrun_q, overrun_d;
    logic [7:0] mask_q,    mask_d;

    logic [7:0] sync_out;
    logic [7:0] rise;
    logic [7:0] ack_hit;

    // Shift every line one stage further down its synchronizer.
    always_comb begin
        sync_d[0] = irq_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Edge detection against the previous synchronized level.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        prev_d   = sync_out;
        rise     = sync_out & ~prev_q;
    end

    // Decode the acknowledge into a one-hot line select.
    always_comb begin
        ack_hit = 8'h00;
        if (ack_valid) begin
            ack_hit[ack_id] = 1'b1;
        end
    end

    // Pending and overrun update.
    // A new edge beats a simultaneous ack: the old edge counts as serviced,
    // so no overrun is raised.
    always_comb begin
        pending_d = rise | (pending_q & ~ack_hit);
        overrun_d = (overrun_q & ~ack_hit) | (rise & pending_q & ~ack_hit);
    end

    // Mask register load.
    always_comb begin
        mask_d = mask_q;
        if (mask_wr) begin
            mask_d = mask_data;
        end
    end

    // All state registers.
    // Reset discards in-flight synchronizer state together with the pending
    // and overrun state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= 8'h00;
            end
            prev_q    <= 8'h00;
            pending_q <= 8'h00;
            overrun_q <= 8'h00;
            mask_q    <= MASK_RESET;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q    <= prev_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            mask_q    <= mask_d;
        end
    end

    // Outputs are derived from registers only, so no input reaches them
    // combinationally.
    always_comb begin
        req_vec = pending_q & mask_q;
        req_en  = |(pending_q & mask_q);
        pending = pending_q;
        overrun = overrun_q;
    end

endmodule
